// File: rtl/calc1_req_sequencer.sv
// Serialises one host operation onto a calc1 requester port and returns its completion (optional CALC1_REQ_CMD_FILTER_EN).
// First cmd_out cycle 1 after acceptance; req_ready low from acceptance until the completion is taken by rsp_ready.
module calc1_req_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic [3:0]  cmd_out,
  output logic [31:0] data_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] data_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic        err_spurious
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND1,
    S_SEND2,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [31:0]       op2;
  logic [CNT_W-1:0]  cnt;
  logic              cmd_ok;

`ifdef CALC1_REQ_CMD_FILTER_EN
  assign cmd_ok = (req_cmd == 4'd1) || (req_cmd == 4'd2) ||
                  (req_cmd == 4'd5) || (req_cmd == 4'd6);
`else
  assign cmd_ok = 1'b1;
`endif

  // Gated with reset so the host never sees ready while the port is held in reset.
  assign req_ready = reset_n && (state == S_IDLE);

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      op2          <= '0;
      cnt          <= '0;
      cmd_out      <= '0;
      data_out     <= '0;
      rsp_valid    <= 1'b0;
      rsp_code     <= '0;
      rsp_data     <= '0;
      err_spurious <= 1'b0;
    end else begin
      if ((resp_in != 2'd0) && (state != S_WAIT))
        err_spurious <= 1'b1;

      case (state)
        S_IDLE: begin
          cmd_out  <= '0;
          data_out <= '0;
          if (req_valid) begin
            op2 <= req_op2;
            if (cmd_ok) begin
              state    <= S_SEND1;
              cmd_out  <= req_cmd;
              data_out <= req_op1;
            end else begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_code  <= 2'd2;
              rsp_data  <= '0;
            end
          end
        end
        S_SEND1: begin
          state    <= S_SEND2;
          cmd_out  <= '0;
          data_out <= op2;
        end
        S_SEND2: begin
          state    <= S_WAIT;
          cmd_out  <= '0;
          data_out <= '0;
          cnt      <= '0;
        end
        S_WAIT: begin
          // A response arriving on the expiry edge takes priority over the timeout.
          if (resp_in != 2'd0) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_code  <= resp_in;
            rsp_data  <= data_in;
          end else if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_code  <= 2'd3;
            rsp_data  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc1_req_sequencer.sv
// Directed bench for calc1_req_sequencer; the bench itself plays the calc1 responder.
module tb_calc1_req_sequencer;

  logic        c_clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  cmd_out;
  logic [31:0] data_out;
  logic [1:0]  resp_in;
  logic [31:0] data_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        err_spurious;

  int errors = 0;
  int checks = 0;

  calc1_req_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .c_clk        (c_clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .cmd_out      (cmd_out),
    .data_out     (data_out),
    .resp_in      (resp_in),
    .data_in      (data_in),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_code     (rsp_code),
    .rsp_data     (rsp_data),
    .err_spurious (err_spurious)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  // Present one operation for exactly one accepting edge.
  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_op1   = a;
    req_op2   = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    resp_in = '0; data_in = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cmd_out",   32'(cmd_out),   32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err",       32'(err_spurious), 32'd0);
    step(); step();
    reset_n = 1'b1;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Add: 1 + 01FF_FFFF, responder answers two cycles after SEND2.
    send(4'd1, 32'h0000_0001, 32'h01FF_FFFF);
    chk("add_send1_cmd",  32'(cmd_out), 32'd1);
    chk("add_send1_data", data_out, 32'h1);
    chk("add_busy_ready", 32'(req_ready), 32'd0);
    step();
    chk("add_send2_cmd",  32'(cmd_out), 32'd0);
    chk("add_send2_data", data_out, 32'h01FF_FFFF);
    step();
    chk("add_wait_data", data_out, 32'h0);
    step();
    chk("add_wait_novld", 32'(rsp_valid), 32'd0);
    resp_in = 2'd1; data_in = 32'h0200_0000;
    step();
    resp_in = 2'd0; data_in = '0;
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_code",  32'(rsp_code), 32'd1);
    chk("add_rsp_data",  rsp_data, 32'h0200_0000);
    take_rsp();
    chk("add_rel_valid", 32'(rsp_valid), 32'd0);
    chk("add_rel_ready", 32'(req_ready), 32'd1);

    // Overflow: FFFF_FFFF + 1, completion held until taken.
    send(4'd1, 32'hFFFF_FFFF, 32'h1);
    step(); step();
    resp_in = 2'd2; data_in = 32'h0;
    step();
    resp_in = 2'd0;
    chk("ovf_rsp_code", 32'(rsp_code), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_hold_ready", 32'(req_ready), 32'd0);
      chk("ovf_hold_valid", 32'(rsp_valid), 32'd1);
    end
    take_rsp();
    chk("ovf_rel_ready", 32'(req_ready), 32'd1);

    // Timeout: silent responder, completion 16 cycles after entering WAIT.
    send(4'd2, 32'h1, 32'hF);
    step(); step();
    for (int i = 0; i < 15; i++) step();
    chk("to_early_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_code",  32'(rsp_code), 32'd3);
    chk("to_rsp_data",  rsp_data, 32'h0);

    // Backpressure for 10 cycles, then a spurious response during DONE.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_code",  32'(rsp_code), 32'd3);
    end
    chk("bp_err_clear", 32'(err_spurious), 32'd0);
    resp_in = 2'd1; data_in = 32'hDEAD_BEEF;
    step();
    resp_in = 2'd0; data_in = '0;
    chk("sp_err",  32'(err_spurious), 32'd1);
    chk("sp_code", 32'(rsp_code), 32'd3);
    chk("sp_data", rsp_data, 32'h0);
    take_rsp();
    chk("sp_sticky", 32'(err_spurious), 32'd1);

    // Response on the expiry edge beats the timeout.
    send(4'd5, 32'h1, 32'h3);
    step(); step();
    for (int i = 0; i < 15; i++) step();
    resp_in = 2'd1; data_in = 32'h8;
    step();
    resp_in = 2'd0; data_in = '0;
    chk("edge_code", 32'(rsp_code), 32'd1);
    chk("edge_data", rsp_data, 32'h8);
    take_rsp();

    // Reset while cmd_out is active clears everything immediately.
    send(4'd1, 32'h5, 32'h6);
    chk("mid_cmd_before", 32'(cmd_out), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_cmd_out",  32'(cmd_out), 32'd0);
    chk("mid_data_out", data_out, 32'h0);
    chk("mid_ready",    32'(req_ready), 32'd0);
    chk("mid_err",      32'(err_spurious), 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_ready", 32'(req_ready), 32'd1);
    send(4'd1, 32'h0, 32'h0);
    step(); step();
    resp_in = 2'd1; data_in = 32'h0;
    step();
    resp_in = 2'd0;
    chk("post_valid", 32'(rsp_valid), 32'd1);
    chk("post_code",  32'(rsp_code), 32'd1);
    chk("post_data",  rsp_data, 32'h0);
    take_rsp();

    // Unsupported command 3.
    send(4'd3, 32'h1, 32'h2);
`ifdef CALC1_REQ_CMD_FILTER_EN
    chk("flt_cmd_out", 32'(cmd_out), 32'd0);
    chk("flt_valid",   32'(rsp_valid), 32'd1);
    chk("flt_code",    32'(rsp_code), 32'd2);
    chk("flt_data",    rsp_data, 32'h0);
`else
    chk("nf_cmd_out", 32'(cmd_out), 32'd3);
    step(); step();
    resp_in = 2'd2; data_in = 32'h0;
    step();
    resp_in = 2'd0;
    chk("nf_code", 32'(rsp_code), 32'd2);
`endif
    take_rsp();
    chk("final_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
